// File: rtl/bidir_pkg.sv
// Shared types and helpers for the bidirectional pad-bus port.
package bidir_pkg;

    // Bus direction states: receiving, turning toward transmit, transmitting,
    // turning back toward receive.
    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_e;

    // Width of the turnaround counter, which counts 0..turn-1.
    // Kept at least one bit so a single-cycle turnaround still has a legal vector.
    function automatic int turnCntWidth(input int turn);
        return (turn > 1) ? $clog2(turn) : 1;
    endfunction

endpackage

// File: rtl/bidir_txfifo.sv
// Transmit FIFO: DEPTH x WIDTH, registered level, full/empty flags.
// A word pushed on an edge only becomes visible at the head afterwards,
// so a push into an empty FIFO cannot be popped on that same edge.
module bidir_txfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           pushData_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           popData_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [LW-1:0]    level_q;
    logic             doPush;
    logic             doPop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign popData_o = mem_q[rdPtr_q];

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Storage array; contents need no reset because the level gates reads.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/bidir_port.sv
// Half-duplex tristate pad port: buffered transmit, direction FSM with
// programmable hi-Z turnaround, and strobe-qualified receive capture.
module bidir_port
    import bidir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TURN  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_mode,
    input  logic                       tx_valid,
    input  logic [WIDTH-1:0]           tx_data,
    output logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] tx_level,
    inout  wire  [WIDTH-1:0]           pad,
    output logic                       stb_out,
    input  logic                       stb_in,
    output logic                       rx_valid,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       dir_tx
);

    localparam int             CW        = turnCntWidth(TURN);
    localparam logic [CW-1:0]  TURN_LAST = CW'(TURN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    turnCnt_q;
    logic [CW-1:0]    turnCnt_d;
    logic [WIDTH-1:0] outWord_q;
    logic             stbOut_q;
    logic [WIDTH-1:0] rxData_q;
    logic             rxValid_q;

    logic             fifoFull;
    logic             fifoEmpty;
    logic [WIDTH-1:0] fifoHead;
    logic             pop;

    assign tx_ready = !fifoFull;

    bidir_txfifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_txfifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (tx_valid),
        .pushData_i (tx_data),
        .pop_i      (pop),
        .popData_o  (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .level_o    (tx_level)
    );

    // Next-state logic: turnaround windows count TURN cycles, and TX only releases the bus once drained.
    always_comb begin
        state_d   = state_q;
        turnCnt_d = turnCnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_RX: begin
                turnCnt_d = '0;
                if (tx_mode) begin
                    state_d = ST_TURN_TX;
                end
            end
            ST_TURN_TX: begin
                if (!tx_mode) begin
                    state_d   = ST_TURN_RX;
                    turnCnt_d = '0;
                end else if (turnCnt_q == TURN_LAST) begin
                    state_d   = ST_TX;
                    turnCnt_d = '0;
                end else begin
                    turnCnt_d = turnCnt_q + CW'(1);
                end
            end
            ST_TX: begin
                turnCnt_d = '0;
                pop       = !fifoEmpty;
                if (!tx_mode && fifoEmpty) begin
                    state_d = ST_TURN_RX;
                end
            end
            ST_TURN_RX: begin
                if (turnCnt_q == TURN_LAST) begin
                    state_d   = ST_RX;
                    turnCnt_d = '0;
                end else begin
                    turnCnt_d = turnCnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_RX;
                turnCnt_d = '0;
            end
        endcase
    end

    // State and turnaround counter; async reset drops the output enable and releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RX;
            turnCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            turnCnt_q <= turnCnt_d;
        end
    end

    // Transmit output register: each pop loads a fresh word and flags it on stb_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outWord_q <= '0;
            stbOut_q  <= 1'b0;
        end else begin
            stbOut_q <= pop;
            if (pop) begin
                outWord_q <= fifoHead;
            end
        end
    end

    // Receive capture: only in RX does the far-end strobe latch the pad word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
        end else begin
            rxValid_q <= (state_q == ST_RX) && stb_in;
            if ((state_q == ST_RX) && stb_in) begin
                rxData_q <= pad;
            end
        end
    end

    assign dir_tx   = (state_q == ST_TX);
    assign stb_out  = stbOut_q;
    assign rx_valid = rxValid_q;
    assign rx_data  = rxData_q;
    assign pad      = dir_tx ? outWord_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_port.sv
// Scoreboard bench for bidir_port: stimulus queues expected words, a negedge
// monitor pops and compares whenever rx_valid or stb_out is presented.
module tb_bidir_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TURN  = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tx_mode;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [LW-1:0]    tx_level;
    wire  [WIDTH-1:0] pad;
    logic             stb_out;
    logic             stb_in;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             dir_tx;

    logic             drvEn;
    logic [WIDTH-1:0] drvData;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] rxExp [$];
    logic [WIDTH-1:0] txExp [$];
    logic [WIDTH-1:0] rxE;
    logic [WIDTH-1:0] txE;
    logic [WIDTH-1:0] burst [4];
    logic [WIDTH-1:0] hiZ;

    assign pad = drvEn ? drvData : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    bidir_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TURN  (TURN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_mode  (tx_mode),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_level (tx_level),
        .pad      (pad),
        .stb_out  (stb_out),
        .stb_in   (stb_in),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .dir_tx   (dir_tx)
    );

    // Four-state compare so hi-Z on the pad is checked exactly.
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for the inactive edge, then drives every core-side and far-end input.
    task automatic applyStimulus(input logic mode, input logic valid, input logic [WIDTH-1:0] data,
                                 input logic stb, input logic den, input logic [WIDTH-1:0] ddata);
        @(negedge clk);
        tx_mode  = mode;
        tx_valid = valid;
        tx_data  = data;
        stb_in   = stb;
        drvEn    = den;
        drvData  = ddata;
    endtask

    // Monitor: every presented output word is matched against the head of its queue.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rxExp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected: got %h expected none", rx_data);
            end else begin
                rxE = rxExp.pop_front();
                checkOutput("rx_data", 16'(rx_data), 16'(rxE));
            end
        end
        if (stb_out === 1'b1) begin
            if (txExp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got %h expected none", pad);
            end else begin
                txE = txExp.pop_front();
                checkOutput("pad_word", 16'(pad), 16'(txE));
            end
        end
    end

    // Watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        hiZ      = {WIDTH{1'bz}};
        burst[0] = 8'h11;
        burst[1] = 8'h22;
        burst[2] = 8'h33;
        burst[3] = 8'h44;
        rst_n    = 1'b0;
        tx_mode  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        stb_in   = 1'b0;
        drvEn    = 1'b0;
        drvData  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_dir_tx", 16'(dir_tx), 16'(1'b0));
        checkOutput("rst_stb_out", 16'(stb_out), 16'(1'b0));
        checkOutput("rst_rx_valid", 16'(rx_valid), 16'(1'b0));
        checkOutput("rst_rx_data", 16'(rx_data), 16'h0);
        checkOutput("rst_tx_level", 16'(tx_level), 16'h0);
        checkOutput("rst_tx_ready", 16'(tx_ready), 16'(1'b1));
        checkOutput("rst_pad", 16'(pad), 16'(hiZ));
        rst_n = 1'b1;

        // Receive two words
        applyStimulus(0, 0, '0, 1, 1, 8'hA5);
        rxExp.push_back(8'hA5);
        applyStimulus(0, 0, '0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("rx_pulse_end", 16'(rx_valid), 16'(1'b0));
        checkOutput("rx_data_held", 16'(rx_data), 16'hA5);
        applyStimulus(0, 0, '0, 1, 1, 8'h3C);
        rxExp.push_back(8'h3C);
        applyStimulus(0, 0, '0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("rx_data_held2", 16'(rx_data), 16'h3C);

        // Queue a burst in RX, then try a fifth push into a full FIFO
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, burst[i], 0, 0, '0);
            txExp.push_back(burst[i]);
        end
        applyStimulus(0, 1, 8'h55, 0, 0, '0);
        checkOutput("full_level", 16'(tx_level), 16'd4);
        checkOutput("full_ready", 16'(tx_ready), 16'(1'b0));
        applyStimulus(1, 0, '0, 0, 0, '0);
        checkOutput("full_reject", 16'(tx_level), 16'd4);
        checkOutput("full_ready2", 16'(tx_ready), 16'(1'b0));

        // Turnaround toward TX: TURN hi-Z cycles, then dir_tx with no word yet
        for (int i = 0; i < TURN; i++) begin
            applyStimulus(1, 0, '0, 1, 0, '0);
            checkOutput("turn_tx_dir", 16'(dir_tx), 16'(1'b0));
            checkOutput("turn_tx_pad", 16'(pad), 16'(hiZ));
        end
        applyStimulus(1, 0, '0, 0, 0, '0);
        checkOutput("tx_enter_dir", 16'(dir_tx), 16'(1'b1));
        checkOutput("tx_enter_stb", 16'(stb_out), 16'(1'b0));
        checkOutput("tx_enter_level", 16'(tx_level), 16'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, '0, 0, 0, '0);
            checkOutput("burst_stb", 16'(stb_out), 16'(1'b1));
            if (i == 0) begin
                checkOutput("pop_ready", 16'(tx_ready), 16'(1'b1));
                checkOutput("pop_level", 16'(tx_level), 16'd3);
            end
        end

        // Drain on direction change; pushes in TX overlap with pops
        applyStimulus(1, 1, 8'h66, 0, 0, '0);
        txExp.push_back(8'h66);
        checkOutput("idle_stb", 16'(stb_out), 16'(1'b0));
        checkOutput("idle_dir", 16'(dir_tx), 16'(1'b1));
        checkOutput("idle_pad_hold", 16'(pad), 16'h44);
        applyStimulus(1, 1, 8'h77, 0, 0, '0);
        txExp.push_back(8'h77);
        checkOutput("push_not_popped", 16'(stb_out), 16'(1'b0));
        checkOutput("lvl_after_push", 16'(tx_level), 16'd1);
        applyStimulus(0, 1, 8'h88, 0, 0, '0);
        txExp.push_back(8'h88);
        checkOutput("lvl_push_pop", 16'(tx_level), 16'd1);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("lvl_push_pop2", 16'(tx_level), 16'd1);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("drain_last_dir", 16'(dir_tx), 16'(1'b1));
        checkOutput("drain_last_lvl", 16'(tx_level), 16'd0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("turn_rx_dir0", 16'(dir_tx), 16'(1'b0));
        checkOutput("turn_rx_pad0", 16'(pad), 16'(hiZ));
        checkOutput("turn_rx_stb0", 16'(stb_out), 16'(1'b0));
        applyStimulus(0, 0, '0, 1, 1, 8'hBB);
        checkOutput("turn_rx_dir1", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 1, 1, 8'hC3);
        rxExp.push_back(8'hC3);
        checkOutput("rx_back_dir", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("rx_back_data", 16'(rx_data), 16'hC3);

        // Abort a TX turnaround: bus never driven, TURN_RX still runs TURN cycles
        applyStimulus(1, 0, '0, 0, 0, '0);
        checkOutput("abort_dir0", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("abort_dir1", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("abort_dir2", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 1, 1, 8'hDD);
        checkOutput("abort_dir3", 16'(dir_tx), 16'(1'b0));
        applyStimulus(0, 0, '0, 1, 1, 8'h5A);
        rxExp.push_back(8'h5A);
        checkOutput("abort_stb", 16'(stb_out), 16'(1'b0));
        applyStimulus(0, 0, '0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("abort_rx_data", 16'(rx_data), 16'h5A);

        // Reset mid-TX with a full FIFO
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'(i + 1), 0, 0, '0);
        end
        applyStimulus(1, 0, '0, 0, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0);
        checkOutput("pre_rst_dir", 16'(dir_tx), 16'(1'b1));
        checkOutput("pre_rst_level", 16'(tx_level), 16'd4);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_pad", 16'(pad), 16'(hiZ));
        checkOutput("mid_rst_dir", 16'(dir_tx), 16'(1'b0));
        checkOutput("mid_rst_level", 16'(tx_level), 16'h0);
        checkOutput("mid_rst_rx_valid", 16'(rx_valid), 16'(1'b0));
        checkOutput("mid_rst_ready", 16'(tx_ready), 16'(1'b1));
        tx_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, '0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, '0);
        checkOutput("post_rst_stb", 16'(stb_out), 16'(1'b0));
        checkOutput("post_rst_level", 16'(tx_level), 16'h0);

        // Every queued word must have been presented
        checkOutput("rx_queue_left", 16'(rxExp.size()), 16'h0);
        checkOutput("tx_queue_left", 16'(txExp.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
